// File: rtl/jt12_mmr_queue_if.sv
// Downstream register-file write port of the JT12 MMR queue.
// Master drives the FIFO head; slave answers with ready.
interface jt12_mmr_queue_if #(
  parameter int BW = 1
);
  logic          wr_valid;
  logic          wr_ready;
  logic [BW-1:0] wr_bank;
  logic [7:0]    wr_reg;
  logic [7:0]    wr_data;

  modport master (
    output wr_valid,
    output wr_bank,
    output wr_reg,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_bank,
    input  wr_reg,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/jt12_mmr_queue.sv
// JT12 CPU front end: write decode, prescaler, write FIFO and busy flag.
// Optional JT12_MMR_STATUS_EN adds a status port and software ovf clear.
module jt12_mmr_queue #(
  parameter  int BANKS       = 2,
  parameter  int DEPTH       = 4,
  parameter  int BUSY_CNT    = 32,
  parameter  int DIV_DEFAULT = 6,
  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  output logic        clk_en,
  input  logic [7:0]  din,
  input  logic [BW:0] addr,
  input  logic        write,
  output logic        busy,
  output logic        ovf,
`ifdef JT12_MMR_STATUS_EN
  output logic [7:0]  status,
`endif
  jt12_mmr_queue_if.master wr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_CNT + 1);
  localparam int EW = BW + 16;

  logic [2:0]    cnt_q;
  logic [2:0]    lim_q, lim_d;
  logic          old_write_q;
  logic [7:0]    sel_reg_q;
  logic [BW-1:0] sel_bank_q;
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  logic [TW-1:0] timer_q;
  logic          busy_q, ovf_q;
  logic [EW-1:0] head;

  logic wr_ev, addr_ev, data_ev;
  logic valid, full, pop, push, drop;
  logic bank0, ovf_clr;

  assign clk_en  = cen & (cnt_q == lim_q);
  assign wr_ev   = write & ~old_write_q;
  assign addr_ev = wr_ev & ~addr[0];
  assign data_ev = wr_ev & addr[0];
  assign valid   = count_q != '0;
  assign full    = count_q == CW'(DEPTH);
  assign pop     = clk_en & valid & wr.wr_ready;
  assign push    = data_ev & (~full | pop);
  assign drop    = data_ev & full & ~pop;
  assign bank0   = sel_bank_q == '0;

`ifdef JT12_MMR_STATUS_EN
  assign ovf_clr = data_ev & bank0 & (sel_reg_q == 8'h27)
                 & (din[7:6] == 2'b11);
`else
  assign ovf_clr = 1'b0;
`endif

  // Prescaler ratio writes take effect immediately, not via the queue
  always_comb begin
    lim_d = lim_q;
    if (data_ev && bank0) begin
      unique case (1'b1)
        sel_reg_q == 8'h2D: lim_d = 3'd5;
        sel_reg_q == 8'h2E: lim_d = 3'd2;
        sel_reg_q == 8'h2F: lim_d = 3'd1;
        default:            lim_d = lim_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {sel_bank_q, sel_reg_q, din};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      lim_q       <= 3'(DIV_DEFAULT - 1);
      old_write_q <= 1'b0;
      sel_reg_q   <= '0;
      sel_bank_q  <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      old_write_q <= write;
      lim_q       <= lim_d;
      // >= also catches a counter stranded above a freshly lowered limit
      if (cen) cnt_q <= (cnt_q >= lim_q) ? 3'd0 : cnt_q + 3'd1;
      if (addr_ev) begin
        sel_reg_q  <= din;
        sel_bank_q <= addr[BW:1];
      end
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (push)
        timer_q <= TW'(BUSY_CNT);
      else if (clk_en && timer_q != '0)
        timer_q <= timer_q - 1'b1;
      if (push)
        busy_q <= 1'b1;
      else if (count_q == '0 && timer_q == '0)
        busy_q <= 1'b0;
      if (drop)
        ovf_q <= 1'b1;
      else if (ovf_clr)
        ovf_q <= 1'b0;
    end
  end

`ifdef JT12_MMR_STATUS_EN
  logic [3:0] cnt_sat;
  logic [7:0] status_q;

  always_comb begin
    cnt_sat = 4'(count_q);
    if (int'(count_q) > 15) cnt_sat = 4'hF;
  end

  always_ff @(posedge clk) begin
    if (rst) status_q <= '0;
    else     status_q <= {busy_q, ovf_q, 2'b00, cnt_sat};
  end

  assign status = status_q;
`endif

  assign head        = valid ? mem_q[rd_q] : '0;
  assign wr.wr_valid = valid;
  assign wr.wr_bank  = head[EW-1:16];
  assign wr.wr_reg   = head[15:8];
  assign wr.wr_data  = head[7:0];
  assign busy        = busy_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_jt12_mmr_queue.sv
// Directed bench for jt12_mmr_queue with default parameters.
// Build with JT12_MMR_STATUS_EN defined to cover the status port.
module tb_jt12_mmr_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b1;
  logic       clk_en;
  logic [7:0] din = '0;
  logic [1:0] addr = '0;
  logic       write = 1'b0;
  logic       busy, ovf;
`ifdef JT12_MMR_STATUS_EN
  logic [7:0] status;
`endif

  jt12_mmr_queue_if #(.BW(1)) wr_if ();

  jt12_mmr_queue dut (
    .clk    (clk),
    .rst    (rst),
    .cen    (cen),
    .clk_en (clk_en),
    .din    (din),
    .addr   (addr),
    .write  (write),
    .busy   (busy),
    .ovf    (ovf),
`ifdef JT12_MMR_STATUS_EN
    .status (status),
`endif
    .wr     (wr_if.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [16:0] log_q[$];

  always @(negedge clk) begin
    if (clk_en && wr_if.wr_valid && wr_if.wr_ready)
      log_q.push_back({wr_if.wr_bank, wr_if.wr_reg, wr_if.wr_data});
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    addr  = a;
    din   = d;
    write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic measure(output int per);
    bit seen;
    int n;
    per  = -1;
    seen = 0;
    n    = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (clk_en) seen = 1;
    end
    if (seen) begin
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        n++;
        if (clk_en) begin
          per = n;
          break;
        end
      end
    end
  endtask

  task automatic wait_tick(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (clk_en) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] reg_a;
    int         per;
  } div_vec_t;

  div_vec_t tbl[4];

  initial begin
    int  per;
    bit  ok;
    int  ticks;
    bit  busy_ok;

    tbl[0] = '{reg_a: 8'h2F, per: 2};
    tbl[1] = '{reg_a: 8'h2E, per: 3};
    tbl[2] = '{reg_a: 8'h2F, per: 2};
    tbl[3] = '{reg_a: 8'h2D, per: 6};

    wr_if.wr_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_clk_en",   clk_en,          0);
    chk("rst_wr_valid", wr_if.wr_valid,  0);
    chk("rst_busy",     busy,            0);
    chk("rst_ovf",      ovf,             0);
    chk("rst_wr_bank",  wr_if.wr_bank,   0);
    chk("rst_wr_reg",   wr_if.wr_reg,    0);
    chk("rst_wr_data",  wr_if.wr_data,   0);
    rst = 1'b0;

    measure(per);
    chk("div_default", per, 6);

    for (int i = 0; i < 4; i++) begin
      cpu_write(2'b00, tbl[i].reg_a);
      cpu_write(2'b01, 8'h00);
      measure(per);
      chk($sformatf("div_reg_%0h", tbl[i].reg_a), per, tbl[i].per);
    end

    // Single transfer and busy hold time
    busy_ok = 0;
    for (int i = 0; i < 2000 && !busy_ok; i++) begin
      @(posedge clk); #1;
      if (!busy) busy_ok = 1;
    end
    chk("idle_before_xfer", busy_ok, 1);
    log_q.delete();
    cpu_write(2'b00, 8'h28);
    cpu_write(2'b01, 8'hF1);
    chk("busy_after_push", busy, 1);
    ticks = 0;
    for (int i = 0; i < 31; i++) begin
      wait_tick(ok);
      if (ok) ticks++;
    end
    @(posedge clk); #1;
    chk("busy_tick31", busy, 1);
    wait_tick(ok);
    if (ok) ticks++;
    chk("tick_count", ticks, 32);
    @(posedge clk);
    @(posedge clk); #1;
    chk("busy_tick32", busy, 0);
    chk("xfer_count", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      chk("xfer_bank", log_q[0][16],   0);
      chk("xfer_reg",  log_q[0][15:8], 8'h28);
      chk("xfer_data", log_q[0][7:0],  8'hF1);
    end

    // Overflow with downstream stalled
    wr_if.wr_ready = 1'b0;
    log_q.delete();
    chk("ovf_pre", ovf, 0);
    cpu_write(2'b10, 8'h40);
    for (int i = 1; i <= 5; i++) cpu_write(2'b11, 8'(i));
    @(posedge clk); #1;
    chk("ovf_set",   ovf,            1);
    chk("ovf_valid", wr_if.wr_valid, 1);
    chk("ovf_bank",  wr_if.wr_bank,  1);
    chk("ovf_reg",   wr_if.wr_reg,   8'h40);
    chk("ovf_head",  wr_if.wr_data,  8'h01);
`ifdef JT12_MMR_STATUS_EN
    chk("status_ovf", status, 8'hC4);
`endif
    wr_if.wr_ready = 1'b1;
    for (int i = 0; i < 100 && log_q.size() < 4; i++) @(posedge clk);
    wait_cycles(20);
    chk("ovf_drain_n", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++)
      chk($sformatf("ovf_drain_%0d", i), log_q[i], {1'b1, 8'h40, 8'(i + 1)});
    chk("ovf_sticky", ovf, 1);
    chk("ovf_empty",  wr_if.wr_valid, 0);

`ifdef JT12_MMR_STATUS_EN
    cpu_write(2'b00, 8'h27);
    cpu_write(2'b01, 8'hC0);
    chk("ovf_sw_clr", ovf, 0);
    @(posedge clk); #1;
    chk("status_ovf_clr", status[6], 0);
`endif

    // Full FIFO: push lands in the same cycle as a pop
    do_reset();
    wr_if.wr_ready = 1'b0;
    cpu_write(2'b00, 8'h50);
    for (int i = 1; i <= 4; i++) cpu_write(2'b01, 8'hA0 + 8'(i));
    log_q.delete();
    wait_tick(ok);
    chk("align_tick", ok, 1);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    addr  = 2'b01;
    din   = 8'hA5;
    write = 1'b1;
    wr_if.wr_ready = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
    wr_if.wr_ready = 1'b0;
    chk("pp_pop_n",  log_q.size(), 1);
    chk("pp_ovf",    ovf, 0);
    chk("pp_head",   wr_if.wr_data, 8'hA2);
`ifdef JT12_MMR_STATUS_EN
    @(posedge clk); #1;
    chk("pp_status_cnt", status[3:0], 4);
`endif
    wr_if.wr_ready = 1'b1;
    wait_cycles(40);
    chk("pp_drain_n", log_q.size(), 5);
    for (int i = 1; i < 5 && i < log_q.size(); i++)
      chk($sformatf("pp_drain_%0d", i), log_q[i][7:0], 8'hA0 + 8'(i + 1));

    // Write held high produces one push
    wr_if.wr_ready = 1'b0;
    log_q.delete();
    cpu_write(2'b00, 8'h60);
    @(posedge clk); #1;
    addr  = 2'b01;
    din   = 8'h77;
    write = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    write = 1'b0;
    wr_if.wr_ready = 1'b1;
    wait_cycles(60);
    chk("hold_n", log_q.size(), 1);
    if (log_q.size() >= 1) chk("hold_data", log_q[0][7:0], 8'h77);

    // Reset flushes queued entries
    wr_if.wr_ready = 1'b0;
    cpu_write(2'b00, 8'h61);
    for (int i = 1; i <= 3; i++) cpu_write(2'b01, 8'(i));
    chk("flush_pre_valid", wr_if.wr_valid, 1);
    log_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("flush_valid", wr_if.wr_valid, 0);
    chk("flush_busy",  busy, 0);
    rst = 1'b0;
    wr_if.wr_ready = 1'b1;
    wait_cycles(30);
    chk("flush_no_xfer", log_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jt12_mmr_queue.md
Name: jt12_mmr_queue

Overview:
- Parametrised CPU-side front end for the JT12 register map.
- Decodes address/data write phases across BANKS register banks and generates the divided clock enable (programmable /6, /3, /2).
- Buffers data writes in a DEPTH-entry FIFO and drains them to the downstream register file through a valid/ready handshake qualified by clk_en.
- Drives the CPU busy flag from queue occupancy plus a per-write busy timer.

Parameters:
- BANKS, 2: number of register banks (power of 2, ≥1); BW = max(1, clog2(BANKS)).
- DEPTH, 4: FIFO entries (power of 2, ≥2).
- BUSY_CNT, 32: clk_en ticks busy is held after each accepted data write (≥1).
- DIV_DEFAULT, 6: reset prescaler ratio; allowed values 6, 3, 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cen  in  1  input clock enable
- clk_en  out  1  divided enable = cen & (cen_cnt == lim)
- din  in  8  CPU data
- addr  in  1+BW  bit0: 0 = address phase, 1 = data phase; bits [BW:1] select the bank
- write  in  1  CPU write strobe, level; acted on at its rising edge
- busy  out  1  CPU busy flag
- ovf  out  1  sticky flag, set when a data write is dropped
- wr_valid  out  1  FIFO head valid
- wr_ready  in  1  downstream can accept
- wr_bank  out  BW  head bank
- wr_reg  out  8  head register number
- wr_data  out  8  head data

Behaviour:
- Reset: clk_en=0, busy=0, ovf=0, wr_valid=0, wr_bank/wr_reg/wr_data=0. FIFO empty, busy timer=0, sel_reg=0, sel_bank=0, lim=DIV_DEFAULT-1, cen_cnt=0. Reset mid-operation flushes all queued entries with no downstream transfer.
- Edge detect: old_write is registered every clk. A write event is (write & !old_write). Exactly one action per rising edge; holding write high has no further effect.
- Address phase (addr[0]=0): sel_reg<=din, sel_bank<=addr[BW:1]. Nothing is queued and busy is unaffected.
- Data phase (addr[0]=1): push {sel_bank, sel_reg, din}.
  - Accepted if count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the entry is dropped and ovf<=1 (sticky until rst).
  - Each accepted push reloads the busy timer to BUSY_CNT.
- Prescaler:
  - cen_cnt increments on each cen and wraps to 0 when cen_cnt==lim.
  - clk_en is combinational from registered cen_cnt/lim, gated by cen.
  - Bank-0 data writes to 0x2D, 0x2E, 0x2F set lim to 5, 2, 1 in the same cycle, bypassing the queue; the entry is still pushed.
  - If cen_cnt>new lim, cen_cnt resets to 0 on the next cen.
- Pop: occurs when clk_en & wr_valid & wr_ready. wr_* present the head combinationally from FIFO storage, and wr_valid=(count!=0).
  - Simultaneous push and pop: count unchanged, ordering preserved.
  - A push into an empty FIFO is visible on wr_valid the next cycle; no same-cycle bypass.
- Busy timer: decrements on each clk_en while non-zero. A reload and a decrement in the same cycle resolve to the reload.
- busy is registered:
  - busy<=1 the cycle after an accepted push.
  - busy<=0 once count==0 and timer==0.
  - A dropped write neither sets nor extends busy.
- Pointers: rd/wr pointers are clog2(DEPTH) bits and wrap naturally; count is clog2(DEPTH)+1 bits.

Optional Feature:
- Macro JT12_MMR_STATUS_EN.
- Defined:
  - Adds output status[7:0] = {busy, ovf, 2'b0, count zero-extended to 4 bits, saturating at 15}. It is registered and updates every clk.
  - ovf is additionally cleared by a bank-0 data write to 0x27 with din[7:6]=2'b11; that same write is queued normally.
- Undefined: no status port; ovf clears only on rst.

Test Plan:
- Reset, DIV_DEFAULT=6, cen=1 constant -> clk_en pulses every 6th clk. Write bank0 0x2F then data 0x00 -> clk_en every 2nd clk from the next wrap. Then 0x2E -> every 3rd clk.
- Address 0x28 then data 0xF1, wr_ready=1 -> one transfer wr_bank=0, wr_reg=0x28, wr_data=0xF1 on the first clk_en after wr_valid rises. busy stays high 32 clk_en ticks after the push, then drops.
- wr_ready=0, five data writes 0x01..0x05 to reg 0x40 bank 1, DEPTH=4 -> entries 0x01..0x04 queued, 0x05 dropped, ovf=1. Then wr_ready=1 -> four transfers in order on successive clk_en pulses.
- FIFO full, data write in the same cycle as a pop -> write accepted, count stays 4, ovf stays 0.
- write held high for 20 clk after a single edge -> exactly one push. Reset asserted with 3 entries queued -> wr_valid=0, busy=0 the cycle after reset; no transfers afterwards.
- With JT12_MMR_STATUS_EN: after the overflow case, status=8'hC4. Write bank0 0x27, data 0xC0 -> ovf clears, status[6]=0.
